// File: rtl/key_exp_ctrl_if.sv
// Control bundle between the AES key-expansion sequencer (master) and its datapath/arbiter (slave).
// abort_in/abort_out exist only when KEY_EXP_ABORT_EN is defined.
interface key_exp_ctrl_if;
  logic       start_in;
  logic [1:0] conf_in;
  logic       sbox_gnt_in;
  logic       busy_out;
  logic       done_out;
  logic [2:0] key_word_sel_out;
  logic       wr_en_out;
  logic [5:0] wr_addr_out;
  logic [2:0] imodk_out;
  logic       rot_en_out;
  logic       sub_en_out;
  logic [3:0] rcon_idx_out;
  logic       sbox_req_out;
`ifdef KEY_EXP_ABORT_EN
  logic       abort_in;
  logic       abort_out;
`endif

  modport master (
`ifdef KEY_EXP_ABORT_EN
    input  abort_in,
    output abort_out,
`endif
    input  start_in, conf_in, sbox_gnt_in,
    output busy_out, done_out, key_word_sel_out, wr_en_out, wr_addr_out,
    output imodk_out, rot_en_out, sub_en_out, rcon_idx_out, sbox_req_out
  );

  modport slave (
`ifdef KEY_EXP_ABORT_EN
    output abort_in,
    input  abort_out,
`endif
    output start_in, conf_in, sbox_gnt_in,
    input  busy_out, done_out, key_word_sel_out, wr_en_out, wr_addr_out,
    input  imodk_out, rot_en_out, sub_en_out, rcon_idx_out, sbox_req_out
  );
endinterface

// File: rtl/key_exp_ctrl.sv
// AES key-expansion sequencer: 1 cycle per plain word, 2+SBOX_LAT per S-box word; stalls in CALC until sbox_gnt_in.
// All outputs are registered. Optional abort path enabled by KEY_EXP_ABORT_EN.
module key_exp_ctrl #(
  parameter int SBOX_LAT = 1
) (
  input  logic           clk_in,
  input  logic           rst_in,
  key_exp_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t     state;
  logic [5:0] i;
  logic [2:0] imodk;
  logic [3:0] rcon;
  logic [2:0] nk_m1;
  logic [5:0] total_m1;
  logic [1:0] lat_cnt;
  logic       busy;
  logic       done;
  logic       wr_en;
  logic       rot_en;
  logic       sub_en;
  logic       sbox_req;
  logic [2:0] key_sel;

  logic [5:0] nxt_i;
  logic       nxt_wrap;
  logic [2:0] nxt_imodk;
  logic [3:0] nxt_rcon;
  logic       nxt_sub;
  logic       last;
  logic       adv;

  // Controls for word i+1 are precomputed so they are stable for its whole duration.
  always_comb begin
    nxt_i     = i + 6'd1;
    nxt_wrap  = (imodk == nk_m1);
    nxt_imodk = nxt_wrap ? 3'd0 : imodk + 3'd1;
    nxt_rcon  = nxt_wrap ? rcon + 4'd1 : rcon;
    nxt_sub   = nxt_wrap || ((nk_m1 == 3'd7) && (nxt_imodk == 3'd4) && (nxt_rcon != 4'd0));
    last      = (i == total_m1);
    adv       = (state == S_LOAD) || (state == S_WRITE) || ((state == S_CALC) && !sub_en);
  end

`ifdef KEY_EXP_ABORT_EN
  logic abort_q;
  assign bus.abort_out = abort_q;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= S_IDLE;
      i        <= '0;
      imodk    <= '0;
      rcon     <= '0;
      nk_m1    <= 3'd3;
      total_m1 <= 6'd43;
      lat_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      rot_en   <= 1'b0;
      sub_en   <= 1'b0;
      sbox_req <= 1'b0;
      key_sel  <= '0;
`ifdef KEY_EXP_ABORT_EN
      abort_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef KEY_EXP_ABORT_EN
      abort_q <= 1'b0;
      if (bus.abort_in && busy) begin
        state    <= S_IDLE;
        i        <= '0;
        imodk    <= '0;
        rcon     <= '0;
        busy     <= 1'b0;
        wr_en    <= 1'b0;
        rot_en   <= 1'b0;
        sub_en   <= 1'b0;
        sbox_req <= 1'b0;
        key_sel  <= '0;
        abort_q  <= 1'b1;
      end else
`endif
      if (adv) begin
        if (last) begin
          state    <= S_DONE;
          i        <= '0;
          imodk    <= '0;
          rcon     <= '0;
          busy     <= 1'b0;
          done     <= 1'b1;
          wr_en    <= 1'b0;
          rot_en   <= 1'b0;
          sub_en   <= 1'b0;
          sbox_req <= 1'b0;
          key_sel  <= '0;
        end else begin
          i      <= nxt_i;
          imodk  <= nxt_imodk;
          rcon   <= nxt_rcon;
          rot_en <= nxt_wrap;
          sub_en <= nxt_sub;
          // rcon stays 0 exactly while i < Nk, i.e. while input key words are copied.
          if (nxt_rcon == 4'd0) begin
            state    <= S_LOAD;
            wr_en    <= 1'b1;
            sbox_req <= 1'b0;
            key_sel  <= nxt_i[2:0];
          end else begin
            state    <= S_CALC;
            wr_en    <= !nxt_sub;
            sbox_req <= nxt_sub;
            key_sel  <= '0;
          end
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start_in) begin
              case (bus.conf_in)
                2'b00: begin nk_m1 <= 3'd3; total_m1 <= 6'd43; end
                2'b01: begin nk_m1 <= 3'd5; total_m1 <= 6'd51; end
                default: begin nk_m1 <= 3'd7; total_m1 <= 6'd59; end
              endcase
              state    <= S_LOAD;
              i        <= '0;
              imodk    <= '0;
              rcon     <= '0;
              busy     <= 1'b1;
              wr_en    <= 1'b1;
              rot_en   <= 1'b0;
              sub_en   <= 1'b0;
              sbox_req <= 1'b0;
              key_sel  <= '0;
            end
          end
          S_CALC: begin
            if (bus.sbox_gnt_in) begin
              state   <= S_WAIT;
              lat_cnt <= '0;
            end
          end
          S_WAIT: begin
            if (lat_cnt == 2'(SBOX_LAT - 1)) begin
              state    <= S_WRITE;
              sbox_req <= 1'b0;
              wr_en    <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign bus.busy_out         = busy;
  assign bus.done_out         = done;
  assign bus.key_word_sel_out = key_sel;
  assign bus.wr_en_out        = wr_en;
  assign bus.wr_addr_out      = i;
  assign bus.imodk_out        = imodk;
  assign bus.rot_en_out       = rot_en;
  assign bus.sub_en_out       = sub_en;
  assign bus.rcon_idx_out     = rcon;
  assign bus.sbox_req_out     = sbox_req;

endmodule

// File: doc/key_exp_ctrl.md
Name: key_exp_ctrl

Overview:
Sequencer for the AES key-expansion datapath. On a start pulse it latches the key-size configuration, then steps word index i through every round-key word. It first copies the Nk input key words, then computes the remaining words. For each computed word it drives RotWord/SubWord/Rcon controls and the round-key RAM write. The S-box is shared with the cipher datapath, and this block requests it through a req/gnt handshake.

Parameters:
SBOX_LAT, 1, cycles from S-box grant to SubWord result valid (1..4)

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  reset, asynchronous, active-high
start_in  in  1  start pulse; sampled only in IDLE
conf_in  in  2  key size: 00 = AES-128 (Nk 4, 44 words), 01 = AES-192 (Nk 6, 52 words), 10 = AES-256 (Nk 8, 60 words), 11 = treated as 10
sbox_gnt_in  in  1  S-box grant from the arbiter
busy_out  out  1  high in LOAD/CALC/WAIT/WRITE
done_out  out  1  one-cycle pulse when expansion is complete
key_word_sel_out  out  3  input key word to copy (valid in LOAD)
wr_en_out  out  1  round-key RAM write strobe
wr_addr_out  out  6  RAM address = current i
imodk_out  out  3  i mod Nk
rot_en_out  out  1  RotWord + Rcon apply: i mod Nk == 0, i >= Nk
sub_en_out  out  1  SubWord apply: rot_en, or (Nk == 8 and i mod 8 == 4)
rcon_idx_out  out  4  i / Nk (1..10), valid when rot_en_out = 1
sbox_req_out  out  1  S-box request

Behaviour:
- Reset: state IDLE, i = 0, imodk = 0, rcon = 0, all outputs 0. A reset mid-operation aborts immediately, and no done_out is produced.
- conf_in is latched on an accepted start. Changes to conf_in while busy are ignored.
- start_in outside IDLE is ignored.
- IDLE: on start_in, go to LOAD with i = 0.
- LOAD: one word per cycle.
  - wr_en = 1, key_word_sel = i, wr_addr = i.
  - After i = Nk-1, go to CALC with i = Nk.
- CALC:
  - If sub_en = 0: wr_en = 1 this cycle, advance i, stay in CALC.
  - If sub_en = 1: sbox_req = 1, wr_en = 0. When sbox_gnt_in is sampled high, go to WAIT; otherwise hold CALC with req asserted.
- WAIT: sbox_req = 1 held through SBOX_LAT cycles, then go to WRITE.
- WRITE: wr_en = 1, sbox_req = 0, advance i, return to CALC.
- i-advance rules:
  - imodk wraps to 0 at Nk-1.
  - rcon increments when imodk wraps.
  - When i = total-1 is written, the next state is DONE instead of CALC.
- DONE: done_out = 1 and busy = 0 for exactly one cycle, then IDLE.
- A start pulse coincident with DONE is ignored. The next start is accepted in IDLE.
- rot_en, sub_en, imodk and rcon_idx are registered, valid and stable for the whole duration of word i, including while waiting on the grant.
- The write address never exceeds total-1. i never wraps past 59.
- Cycle counts with immediate grant, SBOX_LAT = 1:
  - Plain word: 1 cycle. Sub word: 3 cycles (CALC, WAIT, WRITE).
  - AES-128: 4 load + 30 plain + 10 × 3 = 64 busy cycles.
  - AES-192: 6 + 38 + 8 × 3 = 68 busy cycles.
  - AES-256: 8 + 39 + 13 × 3 = 86 busy cycles.
- done_out is asserted in the cycle after the last busy cycle.

Optional Feature:
KEY_EXP_ABORT_EN
- Defined: adds input abort_in (1 bit) and output abort_out (1 bit).
  - abort_in high in any busy state forces IDLE on the next edge.
  - sbox_req and wr_en drop in that same next cycle.
  - abort_out pulses for 1 cycle; done_out is not asserted.
  - abort_in in IDLE or DONE has no effect.
- Undefined: neither port exists, and expansion always runs to completion.

Test Plan:
- AES-128, grant tied high, SBOX_LAT = 1, start -> writes to addr 0..43 in order. sub_en at i = 4, 8, …, 40 with rcon_idx 1..10. busy high 64 cycles, then done pulses once.
- AES-256 -> 13 S-box requests, at i = 8, 12, 16, … 56. rot_en only at multiples of 8, rcon_idx 1..7. Last write addr 59, busy 86 cycles.
- AES-192 with grant withheld 5 cycles at i = 6 -> req held, addr 6 not written, rot_en/rcon_idx = 1 stable. Completes with busy = 73 cycles.
- conf_in toggled 00 -> 10 mid-run, plus a second start_in while busy -> no effect; 44 writes total, single done.
- rst_in asserted at i = 20 -> all outputs 0 asynchronously. A following start restarts at addr 0.
- conf_in = 11 -> identical write/control trace to conf_in = 10. With KEY_EXP_ABORT_EN, abort at i = 10 -> IDLE, abort_out pulse, no done.
